// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit, the PC register, instruction memory and decode.
// The fetch unit connects through the master modport and its environment through the slave modport.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // PC register side
    logic [ADDR_W-1:0] PCIn;
    logic              PCWrite;
    // Control
    logic              FetchEn;
    logic              Flush;
    logic              FetchErr;
    // Instruction memory side
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRead;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;
    // Decode side
    logic [DATA_W-1:0] InstrOut;
    logic [ADDR_W-1:0] InstrPC;
    logic              InstrValid;
    logic              InstrAccept;

    modport master (
        input  PCIn, FetchEn, Flush, MemData, MemReady, InstrAccept,
        output MemAddr, MemRead, InstrOut, InstrPC, InstrValid, PCWrite, FetchErr
    );

    modport slave (
        output PCIn, FetchEn, Flush, MemData, MemReady, InstrAccept,
        input  MemAddr, MemRead, InstrOut, InstrPC, InstrValid, PCWrite, FetchErr
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples the PC, reads instruction memory, hands the
// word to decode and pulses PCWrite so the PC register advances.
//
// Handshakes:
//  - Memory: MemRead rises with MemAddr and both stay constant until the first
//    edge at which MemReady=1; MemData is taken at that edge.
//  - Decode: InstrValid rises with InstrOut/InstrPC and all three stay constant
//    until the first edge at which InstrAccept=1; the word transfers at that edge.
//    Flush withdraws either request without a transfer.
module instr_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    instr_fetch_unit_if.master bus,
    output logic [1:0] DbgState
);

    // Counter wide enough to hold TIMEOUT; a zero TIMEOUT still gets one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam bit TIMEOUT_ON = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  waitCount;
    logic [CNT_W-1:0]  waitCountInc;
    logic [ADDR_W-1:0] memAddr;
    logic              memRead;
    logic [DATA_W-1:0] instrOut;
    logic [ADDR_W-1:0] instrPC;
    logic              instrValid;
    logic              pcWrite;
    logic              fetchErr;

    // Saturating increment of the WAIT-cycle counter.
    always_comb begin
        waitCountInc = waitCount;
        if (waitCount != {CNT_W{1'b1}}) begin
            waitCountInc = waitCount + CNT_W'(1);
        end
    end

    // Fetch sequencer: one state register, all outputs registered alongside it.
    // Priority inside a cycle: Reset > Flush > MemReady > timeout > FetchEn.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= ST_IDLE;
            waitCount  <= '0;
            memAddr    <= '0;
            memRead    <= 1'b0;
            instrOut   <= '0;
            instrPC    <= '0;
            instrValid <= 1'b0;
            pcWrite    <= 1'b0;
            fetchErr   <= 1'b0;
        end else begin
            // PCWrite is a single-cycle pulse; only a completed read raises it.
            pcWrite <= 1'b0;
            if (bus.Flush && (state != ST_ERR)) begin
                // Redirect: drop any outstanding read or held word.
                state      <= ST_IDLE;
                memRead    <= 1'b0;
                instrValid <= 1'b0;
                waitCount  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.FetchEn) begin
                            memAddr   <= bus.PCIn;
                            memRead   <= 1'b1;
                            waitCount <= '0;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.MemReady) begin
                            // A completing read beats a timeout in the same cycle.
                            instrOut   <= bus.MemData;
                            instrPC    <= memAddr;
                            instrValid <= 1'b1;
                            pcWrite    <= 1'b1;
                            memRead    <= 1'b0;
                            state      <= ST_HOLD;
                        end else begin
                            waitCount <= waitCountInc;
                            if (TIMEOUT_ON && (waitCountInc == TIMEOUT_C)) begin
                                memRead  <= 1'b0;
                                fetchErr <= 1'b1;
                                state    <= ST_ERR;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // Returning through IDLE gives the PC register a cycle to
                        // present the advanced PC before the next sample.
                        if (bus.InstrAccept) begin
                            instrValid <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_ERR: begin
                        // Terminal until Reset; Flush has no effect here.
                        memRead    <= 1'b0;
                        instrValid <= 1'b0;
                        fetchErr   <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.MemAddr    = memAddr;
    assign bus.MemRead    = memRead;
    assign bus.InstrOut   = instrOut;
    assign bus.InstrPC    = instrPC;
    assign bus.InstrValid = instrValid;
    assign bus.PCWrite    = pcWrite;
    assign bus.FetchErr   = fetchErr;
    assign DbgState       = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. Driver tasks push the expected
// {InstrPC, InstrOut} of every read they complete; a monitor pops and compares
// whenever the DUT pulses PCWrite.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       Reset;
    logic [1:0] dbg_state;
    int         cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .bus      (bus),
        .DbgState (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each PCWrite pulse marks a freshly presented instruction.
    initial begin
        logic [31:0] exp_v;
        forever begin
            @(negedge CLK);
            if (bus.PCWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pcwrite actual=%h%h expected=none (cycle %0d)",
                             bus.InstrPC, bus.InstrOut, cyc);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("instr_word", {bus.InstrPC, bus.InstrOut}, exp_v);
                    check("instr_valid_with_pcwrite", {31'd0, bus.InstrValid}, 32'd1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.PCIn        = '0;
        bus.FetchEn     = 1'b0;
        bus.Flush       = 1'b0;
        bus.MemData     = '0;
        bus.MemReady    = 1'b0;
        bus.InstrAccept = 1'b0;
    endtask

    // Start a fetch from IDLE and check the read request one edge later.
    task automatic start_fetch(input logic [15:0] pc, input string tag);
        bus.PCIn    = pc;
        bus.FetchEn = 1'b1;
        tick();
        bus.FetchEn = 1'b0;
        check({tag, "_memread"}, {31'd0, bus.MemRead}, 32'd1);
        check({tag, "_memaddr"}, {16'd0, bus.MemAddr}, {16'd0, pc});
    endtask

    // Complete the outstanding read now; expected word goes to the scoreboard.
    task automatic complete_read(input logic [15:0] pc, input logic [15:0] data);
        bus.MemReady = 1'b1;
        bus.MemData  = data;
        exp_q.push_back({pc, data});
        tick();
        bus.MemReady = 1'b0;
    endtask

    task automatic accept_instr();
        bus.InstrAccept = 1'b1;
        tick();
        bus.InstrAccept = 1'b0;
        check("accept_valid_low", {31'd0, bus.InstrValid}, 32'd0);
        check("accept_to_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_memaddr"}, {16'd0, bus.MemAddr}, 32'd0);
        check({tag, "_memread"}, {31'd0, bus.MemRead}, 32'd0);
        check({tag, "_instrout"}, {16'd0, bus.InstrOut}, 32'd0);
        check({tag, "_instrpc"}, {16'd0, bus.InstrPC}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.InstrValid}, 32'd0);
        check({tag, "_pcwrite"}, {31'd0, bus.PCWrite}, 32'd0);
        check({tag, "_fetcherr"}, {31'd0, bus.FetchErr}, 32'd0);
        check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        Reset = 1'b0;
        tick();

        // T1: single fetch, zero-wait memory.
        start_fetch(16'h000F, "t1");
        complete_read(16'h000F, 16'hABCD);

        // T2: decode stalls 5 cycles; word stable, no new read even with FetchEn.
        bus.FetchEn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_valid", {31'd0, bus.InstrValid}, 32'd1);
            check("t2_instr", {bus.InstrPC, bus.InstrOut}, {16'h000F, 16'hABCD});
            check("t2_no_read", {31'd0, bus.MemRead}, 32'd0);
            check("t2_pcwrite_low", {31'd0, bus.PCWrite}, 32'd0);
        end
        bus.FetchEn = 1'b0;
        accept_instr();
        tick();

        // T6: back-to-back fetches with accept held high.
        bus.InstrAccept = 1'b1;
        bus.MemReady    = 1'b1;
        bus.MemData     = 16'h1111;
        bus.PCIn        = 16'h0008;
        bus.FetchEn     = 1'b1;
        exp_q.push_back({16'h0008, 16'h1111});
        tick();
        t0 = cyc;
        check("t6_read1", {bus.MemRead, 15'd0, bus.MemAddr}, {1'b1, 15'd0, 16'h0008});
        tick();
        bus.PCIn    = 16'h001E;
        bus.MemData = 16'h2222;
        exp_q.push_back({16'h001E, 16'h2222});
        tick();
        check("t6_gap_no_read", {31'd0, bus.MemRead}, 32'd0);
        tick();
        check("t6_read2", {bus.MemRead, 15'd0, bus.MemAddr}, {1'b1, 15'd0, 16'h001E});
        check("t6_read_spacing", cyc - t0, 32'd3);
        bus.FetchEn = 1'b0;
        tick();
        tick();
        check("t6_back_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        bus.MemReady    = 1'b0;
        bus.InstrAccept = 1'b0;
        tick();

        // T4: Flush in the same cycle as MemReady discards the data.
        start_fetch(16'h0040, "t4");
        bus.MemReady = 1'b1;
        bus.MemData  = 16'h1234;
        bus.Flush    = 1'b1;
        tick();
        bus.Flush    = 1'b0;
        bus.MemReady = 1'b0;
        check("t4_valid", {31'd0, bus.InstrValid}, 32'd0);
        check("t4_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
        check("t4_memread", {31'd0, bus.MemRead}, 32'd0);
        check("t4_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

        // Flush beats InstrAccept while holding.
        start_fetch(16'h0050, "t4b");
        complete_read(16'h0050, 16'h0C0C);
        bus.Flush       = 1'b1;
        bus.InstrAccept = 1'b1;
        tick();
        bus.Flush       = 1'b0;
        bus.InstrAccept = 1'b0;
        check("t4b_valid", {31'd0, bus.InstrValid}, 32'd0);
        check("t4b_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

        // Boundary: MemReady on the edge the counter would hit TIMEOUT wins.
        start_fetch(16'h0060, "bnd");
        for (int i = 0; i < 14; i++) tick();
        check("bnd_still_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
        check("bnd_memread", {31'd0, bus.MemRead}, 32'd1);
        complete_read(16'h0060, 16'h6666);
        check("bnd_no_err", {31'd0, bus.FetchErr}, 32'd0);
        check("bnd_hold", {30'd0, dbg_state}, {30'd0, S_HOLD});
        accept_instr();

        // T5: Reset while holding a valid instruction.
        start_fetch(16'h0077, "t5");
        complete_read(16'h0077, 16'h5A5A);
        check("t5_valid_before", {31'd0, bus.InstrValid}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("t5");

        // T3: MemReady low 15 cycles -> sticky error.
        start_fetch(16'h0100, "t3");
        for (int i = 0; i < 14; i++) tick();
        check("t3_no_err_yet", {bus.FetchErr, bus.MemRead}, {30'd0, 2'b01});
        tick();
        check("t3_err", {31'd0, bus.FetchErr}, 32'd1);
        check("t3_memread", {31'd0, bus.MemRead}, 32'd0);
        check("t3_state", {30'd0, dbg_state}, {30'd0, S_ERR});
        bus.Flush    = 1'b1;
        bus.FetchEn  = 1'b1;
        bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t3_sticky", {bus.FetchErr, bus.MemRead, bus.InstrValid}, {29'd0, 3'b100});
        check("t3_stays_err", {30'd0, dbg_state}, {30'd0, S_ERR});
        idle_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("t3_reset");

        tick();
        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
